// File: rtl/led_bounce_if.sv
// Bus between the bouncing-LED driver side and the LED bounce monitor.
// The master drives the LED sample strobe; the slave reports decoded sweep status.
interface led_bounce_if #(
  parameter int unsigned CNT_W = 8
) ();
  logic             sample_en;
  logic [7:0]       led;
  logic             clr_err;
  logic [2:0]       pos;
  logic             dir;
  logic             valid;
  logic             locked;
  logic [CNT_W-1:0] bounce_count;
  logic             err_onehot;
  logic             err_step;

  modport master (
    output sample_en, led, clr_err,
    input  pos, dir, valid, locked, bounce_count, err_onehot, err_step
  );

  modport slave (
    input  sample_en, led, clr_err,
    output pos, dir, valid, locked, bounce_count, err_onehot, err_step
  );
endinterface

// File: rtl/led_bounce_monitor.sv
// Samples the one-hot LED bus on each strobe, tracks sweep position and direction,
// counts end-point reversals and raises sticky protocol-violation flags.
module led_bounce_monitor #(
  parameter int unsigned CNT_W = 8
) (
  input logic        inClk,
  input logic        inReset,
  led_bounce_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StAcquire, StTrack} state_e;

  state_e           state_q, state_d;
  logic [2:0]       pos_q, pos_d;
  logic             dir_q, dir_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_oh_q, err_oh_d;
  logic             err_step_q, err_step_d;

  logic       onehot;
  logic [2:0] p;
  logic [2:0] exp_pos;
  logic       exp_rev;
  logic       set_oh;
  logic       set_step;

  assign onehot = $onehot(bus.led);

  always_comb begin
    p = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (bus.led[i]) p = 3'(i);
    end
  end

  // Expected next position while tracking; end points reverse instead of wrapping.
  always_comb begin
    exp_rev = 1'b0;
    if (dir_q) begin
      if (pos_q == 3'd0) begin
        exp_pos = 3'd1;
        exp_rev = 1'b1;
      end else begin
        exp_pos = pos_q - 3'd1;
      end
    end else begin
      if (pos_q == 3'd7) begin
        exp_pos = 3'd6;
        exp_rev = 1'b1;
      end else begin
        exp_pos = pos_q + 3'd1;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    pos_d    = pos_q;
    dir_d    = dir_q;
    cnt_d    = cnt_q;
    set_oh   = 1'b0;
    set_step = 1'b0;

    if (bus.sample_en) begin
      if (!onehot) begin
        set_oh  = 1'b1;
        state_d = StIdle;
      end else begin
        unique case (state_q)
          StIdle: begin
            pos_d   = p;
            state_d = StAcquire;
          end
          StAcquire: begin
            if (p == pos_q) begin
              // repeated sample
            end else if (pos_q != 3'd0 && p == pos_q - 3'd1) begin
              dir_d   = 1'b1;
              pos_d   = p;
              state_d = StTrack;
            end else if (pos_q != 3'd7 && p == pos_q + 3'd1) begin
              dir_d   = 1'b0;
              pos_d   = p;
              state_d = StTrack;
            end else begin
              set_step = 1'b1;
              pos_d    = p;
            end
          end
          StTrack: begin
            if (p == exp_pos) begin
              pos_d = p;
              if (exp_rev) begin
                dir_d = ~dir_q;
                if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
              end
            end else if (p != pos_q) begin
              set_step = 1'b1;
              pos_d    = p;
              state_d  = StAcquire;
            end
          end
          default: state_d = StIdle;
        endcase
      end
    end

    // A newly detected error outranks a simultaneous clear.
    err_oh_d   = set_oh   | (err_oh_q   & ~bus.clr_err);
    err_step_d = set_step | (err_step_q & ~bus.clr_err);
  end

  always_ff @(posedge inClk) begin
    if (inReset) begin
      state_q    <= StIdle;
      pos_q      <= 3'd0;
      dir_q      <= 1'b1;
      cnt_q      <= '0;
      err_oh_q   <= 1'b0;
      err_step_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pos_q      <= pos_d;
      dir_q      <= dir_d;
      cnt_q      <= cnt_d;
      err_oh_q   <= err_oh_d;
      err_step_q <= err_step_d;
    end
  end

  assign bus.pos          = pos_q;
  assign bus.dir          = dir_q;
  assign bus.valid        = (state_q != StIdle);
  assign bus.locked       = (state_q == StTrack);
  assign bus.bounce_count = cnt_q;
  assign bus.err_onehot   = err_oh_q;
  assign bus.err_step     = err_step_q;

endmodule

// File: tb/tb_led_bounce_monitor.sv
// Scoreboard bench for led_bounce_monitor: an 8-bit-counter and a 2-bit-counter
// instance share stimulus; a behavioural model queues the expected outputs.
module tb_led_bounce_monitor;

  logic clk;
  logic rst;

  led_bounce_if #(.CNT_W(8)) bus8 ();
  led_bounce_if #(.CNT_W(2)) bus2 ();

  led_bounce_monitor #(.CNT_W(8)) u_dut8 (
    .inClk   (clk),
    .inReset (rst),
    .bus     (bus8.slave)
  );

  led_bounce_monitor #(.CNT_W(2)) u_dut2 (
    .inClk   (clk),
    .inReset (rst),
    .bus     (bus2.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int pos;
    int dir;
    int valid;
    int locked;
    int cnt8;
    int cnt2;
    int eoh;
    int est;
  } exp_t;

  exp_t  sb_q[$];
  int    n_tests = 0;
  int    n_fail  = 0;
  string phase   = "init";

  // Model state: st 0 = idle, 1 = acquire, 2 = track.
  int m_st, m_pos, m_dir, m_cnt8, m_cnt2, m_eoh, m_est;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s/%s: got %0d, expected %0d", phase, tag, got, exp);
    end
  endtask

  task automatic model_step(input bit r, input bit se, input logic [7:0] l, input bit clr);
    int   p;
    int   nxt;
    bit   rev;
    bit   soh;
    bit   sst;
    exp_t e;
    soh = 1'b0;
    sst = 1'b0;
    if (r) begin
      m_st = 0; m_pos = 0; m_dir = 1; m_cnt8 = 0; m_cnt2 = 0; m_eoh = 0; m_est = 0;
    end else begin
      if (se) begin
        if ($countones(l) != 1) begin
          soh  = 1'b1;
          m_st = 0;
        end else begin
          p = $clog2(l);
          if (m_st == 0) begin
            m_pos = p;
            m_st  = 1;
          end else if (m_st == 1) begin
            if (p == m_pos) begin
            end else if (p == m_pos - 1) begin
              m_dir = 1; m_pos = p; m_st = 2;
            end else if (p == m_pos + 1) begin
              m_dir = 0; m_pos = p; m_st = 2;
            end else begin
              sst = 1'b1; m_pos = p;
            end
          end else begin
            nxt = m_dir ? m_pos - 1 : m_pos + 1;
            rev = 1'b0;
            if (nxt < 0) begin nxt = 1; rev = 1'b1; end
            if (nxt > 7) begin nxt = 6; rev = 1'b1; end
            if (p == nxt) begin
              m_pos = p;
              if (rev) begin
                m_dir  = 1 - m_dir;
                m_cnt8 = (m_cnt8 < 255) ? m_cnt8 + 1 : 255;
                m_cnt2 = (m_cnt2 < 3) ? m_cnt2 + 1 : 3;
              end
            end else if (p != m_pos) begin
              sst = 1'b1; m_pos = p; m_st = 1;
            end
          end
        end
      end
      m_eoh = (soh || (m_eoh != 0 && !clr)) ? 1 : 0;
      m_est = (sst || (m_est != 0 && !clr)) ? 1 : 0;
    end
    e.pos = m_pos; e.dir = m_dir; e.valid = (m_st != 0); e.locked = (m_st == 2);
    e.cnt8 = m_cnt8; e.cnt2 = m_cnt2; e.eoh = m_eoh; e.est = m_est;
    sb_q.push_back(e);
  endtask

  task automatic compare_out();
    exp_t e;
    if (sb_q.size() == 0) begin
      check_val("sb_empty", 32'd1, 32'd0);
      return;
    end
    e = sb_q.pop_front();
    check_val("pos",    bus8.pos,          e.pos);
    check_val("dir",    bus8.dir,          e.dir);
    check_val("valid",  bus8.valid,        e.valid);
    check_val("locked", bus8.locked,       e.locked);
    check_val("cnt8",   bus8.bounce_count, e.cnt8);
    check_val("err_oh", bus8.err_onehot,   e.eoh);
    check_val("err_st", bus8.err_step,     e.est);
    check_val("cnt2",   bus2.bounce_count, e.cnt2);
    check_val("pos2",   bus2.pos,          e.pos);
  endtask

  task automatic cycle(input bit r, input bit se, input logic [7:0] l, input bit clr);
    @(negedge clk);
    rst = r;
    bus8.sample_en = se; bus8.led = l; bus8.clr_err = clr;
    bus2.sample_en = se; bus2.led = l; bus2.clr_err = clr;
    model_step(r, se, l, clr);
    @(posedge clk);
    #1;
    compare_out();
  endtask

  task automatic samp(input logic [7:0] l);
    cycle(1'b0, 1'b1, l, 1'b0);
  endtask

  task automatic do_reset();
    cycle(1'b1, 1'b0, 8'h00, 1'b0);
  endtask

  // Direct spot checks of values called out for specific scenarios.
  task automatic spot(input string tag, input logic [31:0] got, input logic [31:0] exp);
    check_val(tag, got, exp);
  endtask

  initial begin
    int wpos;
    int wdir;
    rst = 1'b1;
    bus8.sample_en = 1'b0; bus8.led = 8'h00; bus8.clr_err = 1'b0;
    bus2.sample_en = 1'b0; bus2.led = 8'h00; bus2.clr_err = 1'b0;

    phase = "reset";
    do_reset();
    cycle(1'b0, 1'b0, 8'h00, 1'b0);

    phase = "acquire";
    samp(8'h80);
    samp(8'h40);
    spot("pos6", bus8.pos, 6);
    spot("lock", bus8.locked, 1);
    samp(8'h20);
    spot("pos5", bus8.pos, 5);

    phase = "sweep";
    do_reset();
    for (int i = 7; i >= 0; i--) samp(8'(1 << i));
    cycle(1'b0, 1'b0, 8'hFF, 1'b0);
    for (int i = 1; i <= 7; i++) samp(8'(1 << i));
    samp(8'h40);
    spot("bounce2", bus8.bounce_count, 2);
    spot("dir1", bus8.dir, 1);

    phase = "repeat";
    do_reset();
    samp(8'h80); samp(8'h40); samp(8'h20); samp(8'h10);
    samp(8'h10);
    samp(8'h04);
    spot("pos2", bus8.pos, 2);
    spot("err_step", bus8.err_step, 1);

    phase = "onehot";
    samp(8'h00);
    samp(8'h18);
    spot("valid0", bus8.valid, 0);
    samp(8'h08);
    spot("pos3", bus8.pos, 3);

    phase = "saturate";
    do_reset();
    wpos = 7;
    wdir = 1;
    samp(8'h80);
    for (int k = 0; k < 36; k++) begin
      if (wdir == 1 && wpos == 0) wdir = 0;
      else if (wdir == 0 && wpos == 7) wdir = 1;
      wpos = (wdir == 1) ? wpos - 1 : wpos + 1;
      samp(8'(1 << wpos));
    end
    spot("sat3", bus2.bounce_count, 3);
    spot("cnt5", bus8.bounce_count, 5);

    phase = "clr_err";
    samp(8'h00);
    cycle(1'b0, 1'b1, 8'h03, 1'b1);
    spot("set_wins", bus8.err_onehot, 1);
    cycle(1'b0, 1'b0, 8'h00, 1'b1);
    spot("cleared", bus8.err_onehot, 0);

    phase = "mid_reset";
    samp(8'h02); samp(8'h01); samp(8'h02);
    cycle(1'b1, 1'b1, 8'h04, 1'b0);
    spot("rst_locked", bus8.locked, 0);
    samp(8'h20);
    samp(8'h10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/led_bounce_monitor.md
# led_bounce_monitor

Receiving end of the bouncing-LED bus: samples the 8-bit one-hot LED pattern on a qualifying strobe, decodes the lit position, tracks the sweep direction, counts end-point bounces and flags protocol violations. It sits beside the LED driver in the tone-organ top level, runs on the fast system clock and lets the design and bench check the LED sweep without probing the pins.

## Interface
- CNT_W, default 8: width of the bounce counter.
- inClk  in  1  system clock; all logic on rising edge.
- inReset  in  1  synchronous, active-high reset.
- sample_en  in  1  one-cycle strobe; led is sampled only when high (pulsed once per LED-driver tick).
- led  in  8  LED bus from the driver; bit 7 = leftmost.
- clr_err  in  1  clears the sticky error flags.
- pos  out  3  index of the lit bit from the last accepted sample.
- dir  out  1  1 = moving right (toward bit 0), 0 = moving left (toward bit 7).
- valid  out  1  pos holds a decoded position.
- locked  out  1  direction established (state TRACK).
- bounce_count  out  CNT_W  number of end-point reversals; saturates at all-ones.
- err_onehot  out  1  sticky: a sample had zero or several bits set.
- err_step  out  1  sticky: a sample was not the expected next position.

## Operation
- States: IDLE (no position), ACQUIRE (position known, direction unknown), TRACK (position and direction known).
- Nothing changes on cycles with sample_en = 0, except clr_err.
- Sample with led not one-hot (0x00 or ≥2 bits set): err_onehot <= 1, valid <= 0, locked <= 0, state -> IDLE; pos, dir and bounce_count hold.
- One-hot sample, p = index of the set bit:
  - IDLE: pos <= p, valid <= 1, state -> ACQUIRE.
  - ACQUIRE: p == pos: no change. p == pos-1: dir <= 1, pos <= p, TRACK. p == pos+1: dir <= 0, pos <= p, TRACK. Otherwise: err_step <= 1, pos <= p, stay ACQUIRE.
  - TRACK, expected next e: dir = 1 and pos > 0 gives e = pos-1. dir = 1 and pos = 0 gives e = 1 with reversal. dir = 0 and pos < 7 gives e = pos+1. dir = 0 and pos = 7 gives e = 6 with reversal.
  - TRACK, p == e: pos <= p. On a reversal, also dir <= ~dir and bounce_count increments, saturating at 2^CNT_W-1.
  - TRACK, p == pos: repeated sample, no change, no error.
  - TRACK, any other p (including a reversal away from an end point): err_step <= 1, pos <= p, state -> ACQUIRE, locked <= 0.
- clr_err = 1 clears err_onehot and err_step. If an error is detected in the same cycle, the set wins.
- Arithmetic on pos is 3-bit; pos-1 at 0 and pos+1 at 7 never form a match, because end points are handled by the reversal rule.

## Timing
- All outputs registered; the effect of a sample appears on the cycle after the sample_en cycle (latency 1).
- Reset values: pos = 0, dir = 1, valid = 0, locked = 0, bounce_count = 0, err_onehot = 0, err_step = 0, state IDLE.
- Reset has priority over sample_en and clr_err. Reset mid-sweep returns to IDLE; the next sample re-acquires.
- sample_en may be high on consecutive cycles; each cycle is an independent sample.
- No combinational path from inputs to outputs.

## Test plan
- Reset, then samples 0x80, 0x40, 0x20 -> after 2nd sample pos = 6, dir = 1, locked = 1; after 3rd sample pos = 5; no errors.
- Full sweep from 0x80 down to 0x01 and back up to 0x80, then 0x40 -> bounce_count = 2, dir = 1, pos = 6, no errors.
- In TRACK at pos = 4, dir = 1, sample 0x10 twice, then 0x04 -> 2nd sample no change; 3rd sample err_step = 1, pos = 2, locked = 0.
- Samples 0x00 then 0x18 -> err_onehot = 1, valid = 0, state IDLE; next 0x08 gives valid = 1, pos = 3.
- With CNT_W = 2, run 5 bounces -> bounce_count holds at 3.
- Error pending with clr_err = 1 on the same cycle as a bad sample 0x03 -> err_onehot stays 1. clr_err alone next cycle -> 0. inReset during TRACK -> all outputs return to reset values on the next cycle.
